// File: rtl/adat_checker_if.sv
// Bit-stream and status bundle between the serial receiver front end and adat_checker.
// The receive side is the master; the checker is the slave.
interface adat_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear_cnt;
  logic             locked;
  logic             err_strobe;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [4:0]       phase;

  modport master (
    output bit_in, bit_valid, clear_cnt,
    input  locked, err_strobe, err_cnt, bit_cnt, phase
  );

  modport slave (
    input  bit_in, bit_valid, clear_cnt,
    output locked, err_strobe, err_cnt, bit_cnt, phase
  );
endinterface

// File: rtl/adat_checker.sv
// Aligns to the repeating 28-bit test pattern (search/verify/lock) and counts bit errors
// once locked.
module adat_checker #(
  parameter logic [27:0] PATTERN     = 28'h6CC1555,
  parameter int unsigned VERIFY_BITS = 28,
  parameter int unsigned WIN         = 64,
  parameter int unsigned LOSS_ERR    = 4,
  parameter int unsigned CNT_W       = 16
) (
  input logic           clock,
  input logic           rst,
  adat_checker_if.slave bus
);

  localparam int unsigned VcntW = $clog2(VERIFY_BITS + 1);
  localparam int unsigned WcntW = $clog2(WIN);
  localparam int unsigned WerrW = $clog2(LOSS_ERR + 1);

  localparam logic [VcntW-1:0] VerifyLast = VcntW'(VERIFY_BITS - 1);
  localparam logic [WcntW-1:0] WinLast    = WcntW'(WIN - 1);
  localparam logic [WerrW-1:0] LossErr    = WerrW'(LOSS_ERR);

  typedef enum logic [1:0] {StSearch, StVerify, StLock} state_e;

  state_e           state_q, state_d;
  logic [26:0]      hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [4:0]       phase_q, phase_d;
  logic [VcntW-1:0] vcnt_q, vcnt_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [WerrW-1:0] werr_q, werr_d;
  logic             locked_q, locked_d;
  logic             err_strobe_q, err_strobe_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic [27:0]      nh;
  logic             mismatch;
  logic [4:0]       phase_next;
  logic [WerrW-1:0] werr_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    nh         = {hist_q, bus.bit_in};
    mismatch   = bus.bit_in != PATTERN[phase_q];
    phase_next = (phase_q == 5'd0) ? 5'd27 : phase_q - 5'd1;
    werr_inc   = werr_q + WerrW'(mismatch);

    state_d      = state_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    phase_d      = phase_q;
    vcnt_d       = vcnt_q;
    wcnt_d       = wcnt_q;
    werr_d       = werr_q;
    locked_d     = locked_q;
    err_strobe_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    bit_cnt_d    = bit_cnt_q;

    if (bus.bit_valid) begin
      hist_d = nh[26:0];
      fill_d = (fill_q == 5'd28) ? fill_q : fill_q + 5'd1;
      case (state_q)
        StSearch: begin
          // fill counts bits before this one, so >=27 means a full 28-bit window
          if (fill_q >= 5'd27 && nh == PATTERN) begin
            state_d = StVerify;
            phase_d = 5'd27;
            vcnt_d  = '0;
          end
        end
        StVerify: begin
          if (mismatch) begin
            err_strobe_d = 1'b1;
            state_d      = StSearch;
            fill_d       = '0;
            phase_d      = '0;
          end else begin
            phase_d = phase_next;
            vcnt_d  = vcnt_q + VcntW'(1);
            if (vcnt_q == VerifyLast) begin
              state_d  = StLock;
              locked_d = 1'b1;
              wcnt_d   = '0;
              werr_d   = '0;
            end
          end
        end
        StLock: begin
          bit_cnt_d    = sat_inc(bit_cnt_q);
          err_strobe_d = mismatch;
          if (mismatch) err_cnt_d = sat_inc(err_cnt_q);
          phase_d = phase_next;
          // Loss of lock outranks the end-of-window clear
          if (werr_inc >= LossErr) begin
            state_d  = StSearch;
            locked_d = 1'b0;
            fill_d   = '0;
            phase_d  = '0;
            wcnt_d   = '0;
            werr_d   = '0;
          end else if (wcnt_q == WinLast) begin
            wcnt_d = '0;
            werr_d = '0;
          end else begin
            wcnt_d = wcnt_q + WcntW'(1);
            werr_d = werr_inc;
          end
        end
        default: state_d = StSearch;
      endcase
    end

    if (bus.clear_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= StSearch;
      hist_q       <= '0;
      fill_q       <= '0;
      phase_q      <= '0;
      vcnt_q       <= '0;
      wcnt_q       <= '0;
      werr_q       <= '0;
      locked_q     <= 1'b0;
      err_strobe_q <= 1'b0;
      err_cnt_q    <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      phase_q      <= phase_d;
      vcnt_q       <= vcnt_d;
      wcnt_q       <= wcnt_d;
      werr_q       <= werr_d;
      locked_q     <= locked_d;
      err_strobe_q <= err_strobe_d;
      err_cnt_q    <= err_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_strobe = err_strobe_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_adat_checker.sv
// Directed bench for adat_checker: a table of stream segments with hand-computed results,
// followed by sequences for alignment, window-edge loss, clear, reset and VERIFY errors.
module tb_adat_checker;

  localparam logic [27:0] PATTERN = 28'h6CC1555;

  logic clock = 1'b0;
  logic rst;

  adat_checker_if #(.CNT_W(16)) bus ();

  adat_checker #(.CNT_W(16)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          nbits;
    bit          flip;
    logic        locked;
    logic [4:0]  phase;
    int          err;
    int          bits;
    int          strobes;
  } step_t;

  step_t       steps[12];
  logic [27:0] pat;
  int          tx_idx;
  int          strobes;
  int          n_checks;
  int          n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic b, input logic clr);
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.clear_cnt = clr;
    @(posedge clock);
    #1;
    bus.bit_valid = 1'b0;
    bus.clear_cnt = 1'b0;
    if (bus.err_strobe) strobes++;
  endtask

  // Sends the next stream bit (optionally corrupted) and then `gap` idle cycles
  task automatic send(input bit flip, input bit clr, input int gap);
    cycle(1'b1, pat[tx_idx] ^ flip, clr);
    tx_idx = (tx_idx == 0) ? 27 : tx_idx - 1;
    repeat (gap) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic l, input logic s, input int e,
                           input int b, input logic [4:0] p);
    check({tag, ".locked"}, 32'(bus.locked), 32'(l));
    check({tag, ".err_strobe"}, 32'(bus.err_strobe), 32'(s));
    check({tag, ".err_cnt"}, 32'(bus.err_cnt), e);
    check({tag, ".bit_cnt"}, 32'(bus.bit_cnt), b);
    check({tag, ".phase"}, 32'(bus.phase), 32'(p));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    strobes  = 0;
    pat      = PATTERN;
    tx_idx   = 27;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.clear_cnt = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    check_all("reset", 1'b0, 1'b0, 0, 0, 5'd0);

    //            name        n    flip lock phase err bits strobes
    steps[0]  = '{"sync",     28,  0,   0,   27,   0,  0,   0};
    steps[1]  = '{"verify",   27,  0,   0,   0,    0,  0,   0};
    steps[2]  = '{"lock",     1,   0,   1,   27,   0,  0,   0};
    steps[3]  = '{"clean200", 200, 0,   1,   23,   0,  200, 0};
    steps[4]  = '{"w1err1",   10,  1,   1,   13,   1,  210, 1};
    steps[5]  = '{"w1err2",   10,  1,   1,   3,    2,  220, 1};
    steps[6]  = '{"w1err3",   10,  1,   1,   21,   3,  230, 1};
    steps[7]  = '{"winend",   26,  0,   1,   23,   3,  256, 0};
    steps[8]  = '{"w2err1",   5,   1,   1,   18,   4,  261, 1};
    steps[9]  = '{"w2err2",   5,   1,   1,   13,   5,  266, 1};
    steps[10] = '{"w2err3",   5,   1,   1,   8,    6,  271, 1};
    steps[11] = '{"w2loss",   5,   1,   0,   0,    7,  276, 1};

    for (int k = 0; k < 12; k++) begin
      strobes = 0;
      for (int i = 0; i < steps[k].nbits; i++) send(steps[k].flip && (i == steps[k].nbits - 1), 1'b0, 0);
      check_all(steps[k].name, steps[k].locked, steps[k].flip, steps[k].err, steps[k].bits,
                steps[k].phase);
      check({steps[k].name, ".strobes"}, strobes, steps[k].strobes);
    end

    // Stream rotated left by 13: first full pattern ends on bit 43
    do_reset();
    tx_idx = 14;
    for (int i = 0; i < 42; i++) send(1'b0, 1'b0, 0);
    check("rot13.no_early_verify", 32'(bus.phase), 32'd0);
    send(1'b0, 1'b0, 0);
    check("rot13.verify_phase", 32'(bus.phase), 32'd27);
    for (int i = 0; i < 28; i++) send(1'b0, 1'b0, 0);
    check("rot13.locked", 32'(bus.locked), 32'd1);
    check("rot13.phase", 32'(bus.phase), 32'd27);

    // Fourth window error lands on the last window bit: loss beats the window clear
    strobes = 0;
    for (int i = 0; i < 60; i++) send(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 0);
    check("edge.locked_after3", 32'(bus.locked), 32'd1);
    send(1'b1, 1'b0, 0);
    check("edge.locked_after4", 32'(bus.locked), 32'd0);
    check("edge.phase", 32'(bus.phase), 32'd0);
    check("edge.err_cnt", 32'(bus.err_cnt), 32'd4);
    check("edge.bit_cnt", 32'(bus.bit_cnt), 32'd64);
    check("edge.strobes", strobes, 32'd4);

    // clear_cnt coincident with an erroneous locked bit
    do_reset();
    tx_idx = 27;
    for (int i = 0; i < 56; i++) send(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 0);
    check("clr.bit_cnt_before", 32'(bus.bit_cnt), 32'd5);
    send(1'b1, 1'b1, 0);
    check_all("clr", 1'b1, 1'b1, 0, 0, 5'(tx_idx));
    cycle(1'b0, 1'b0, 1'b0);
    check("clr.strobe_one_cycle", 32'(bus.err_strobe), 32'd0);

    // Reset while locked, with an erroneous bit in the same cycle
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 0);
    send(1'b1, 1'b0, 0);
    check("prerst.err_cnt", 32'(bus.err_cnt), 32'd1);
    check("prerst.bit_cnt", 32'(bus.bit_cnt), 32'd4);
    rst = 1'b1;
    send(1'b1, 1'b0, 0);
    rst = 1'b0;
    check_all("rst_lock", 1'b0, 1'b0, 0, 0, 5'd0);

    // Sparse strobes: error on the 10th VERIFY bit, then a full fresh relock
    tx_idx = 27;
    for (int i = 0; i < 28; i++) send(1'b0, 1'b0, 2);
    check("verr.entry_phase", 32'(bus.phase), 32'd27);
    for (int i = 0; i < 9; i++) send(1'b0, 1'b0, 2);
    send(1'b1, 1'b0, 0);
    check_all("verr", 1'b0, 1'b1, 0, 0, 5'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("verr.strobe_one_cycle", 32'(bus.err_strobe), 32'd0);
    for (int i = 0; i < 18; i++) send(1'b0, 1'b0, 2);
    check("verr.needs_fresh_fill", 32'(bus.phase), 32'd0);
    for (int i = 0; i < 28; i++) send(1'b0, 1'b0, 2);
    check("verr.reverify", 32'(bus.phase), 32'd27);
    for (int i = 0; i < 28; i++) send(1'b0, 1'b0, 2);
    check_all("verr.relock", 1'b1, 1'b0, 0, 0, 5'd27);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
